// File: rtl/mem_pkg.sv
// Shared definitions for the dual-read data memory.
//   RDW_OLD / RDW_NEW : read-during-write selection values for RDW_MODE.
//   clr_state_t       : bulk-clear engine states.
//   be_merge()        : byte-enable merge of a new word into an old word.
// Words up to MAX_WORD_SIZE bits are supported.
// Callers zero-extend their operands and truncate the result.
package mem_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  localparam int MAX_WORD_SIZE = 256;
  localparam int MAX_BE        = MAX_WORD_SIZE / 8;

  typedef enum logic {
    IDLE,
    CLEARING
  } clr_state_t;

  // Byte i of the result comes from newWord when be[i] is set.
  // Otherwise it comes from oldWord.
  function automatic logic [MAX_WORD_SIZE-1:0] be_merge(
    input logic [MAX_WORD_SIZE-1:0] oldWord,
    input logic [MAX_WORD_SIZE-1:0] newWord,
    input logic [MAX_BE-1:0]        be
  );
    logic [MAX_WORD_SIZE-1:0] merged;
    merged = oldWord;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) merged[8*i +: 8] = newWord[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_read_port.sv
// One registered read port of the data memory.
//   clk, rst : clock and async active-high reset
//   busy     : bulk clear running; requests are dropped and data is held
//   rdEn     : read request
//   rdAdr    : read address
//   memWord  : array contents at rdAdr (pre-write value)
//   wrDone   : a write or single-word clear is performed this cycle
//   wrAdr    : address of that write or clear
//   wrWord   : post-write word for wrAdr
//   rdData   : registered read data
//   rdVld    : high for one cycle after an accepted request
module mem_read_port
  import mem_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int WORD_COUNT = 128,
  parameter int RDW_MODE   = RDW_OLD,
  parameter int AW         = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 busy,
  input  logic                 rdEn,
  input  logic [AW-1:0]        rdAdr,
  input  logic [WORD_SIZE-1:0] memWord,
  input  logic                 wrDone,
  input  logic [AW-1:0]        wrAdr,
  input  logic [WORD_SIZE-1:0] wrWord,
  output logic [WORD_SIZE-1:0] rdData,
  output logic                 rdVld
);

  localparam logic [AW:0] WORD_COUNT_W = (AW+1)'(WORD_COUNT);

  logic                 inRange;
  logic                 rdwHit;
  logic                 accept;
  logic [WORD_SIZE-1:0] nextWord;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    inRange  = {1'b0, rdAdr} < WORD_COUNT_W;
    rdwHit   = wrDone && (rdAdr == wrAdr);
    accept   = rdEn && !busy;
    nextWord = memWord;
    if (!inRange) begin
      nextWord = '0;
    end else if (RDW_MODE == RDW_NEW && rdwHit) begin
      nextWord = wrWord;
    end
  end

  // NOTE: state registers use non-blocking assignments.
  // Every flop then samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdData <= '0;
      rdVld  <= 1'b0;
    end else begin
      rdVld <= accept;
      if (accept) rdData <= nextWord;
    end
  end

endmodule

// File: rtl/dual_read_data_mem.sv
// Data memory with one write/clear port and two registered read ports.
// Port A feeds the datapath; port B feeds the controller or debug.
//   clk, rst            : clock and async active-high reset (reset starts a bulk clear)
//   wr_en/wr_adr/wr_data/wr_be : byte-enabled write
//   clr                 : zero the word at wr_adr (wins over wr_en)
//   clr_all             : start or restart a sequential bulk clear
//   rd_en_x/rd_adr_x    : read request on port x (A or B)
//   rd_data_x/rd_vld_x  : read result on port x, one cycle after the request
//   busy                : bulk clear in progress; writes, clears and reads are ignored
module dual_read_data_mem
  import mem_pkg::*;
#(
  parameter  int WORD_SIZE  = 32,
  parameter  int WORD_COUNT = 128,
  parameter  int RDW_MODE   = RDW_OLD,
  localparam int AW         = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1,
  localparam int BE         = WORD_SIZE / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_adr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [BE-1:0]        wr_be,
  input  logic                 clr,
  input  logic                 clr_all,
  input  logic                 rd_en_a,
  input  logic [AW-1:0]        rd_adr_a,
  output logic [WORD_SIZE-1:0] rd_data_a,
  output logic                 rd_vld_a,
  input  logic                 rd_en_b,
  input  logic [AW-1:0]        rd_adr_b,
  output logic [WORD_SIZE-1:0] rd_data_b,
  output logic                 rd_vld_b,
  output logic                 busy
);

  localparam logic [AW:0]   WORD_COUNT_W = (AW+1)'(WORD_COUNT);
  localparam logic [AW-1:0] LAST_ADR     = AW'(WORD_COUNT - 1);

  logic [WORD_SIZE-1:0] mem [WORD_COUNT];

  clr_state_t           state;
  logic [AW-1:0]        clrCnt;

  logic                 userOp;
  logic [WORD_SIZE-1:0] mergedWord;
  logic [WORD_SIZE-1:0] postWord;
  logic                 memWe;
  logic [AW-1:0]        memWadr;
  logic [WORD_SIZE-1:0] memWdata;

  // A user write or clear happens only in IDLE, when no bulk clear is being started,
  // and only for an in-range address.
  assign userOp     = (state == IDLE) && !clr_all && (clr || wr_en) &&
                      ({1'b0, wr_adr} < WORD_COUNT_W);
  assign mergedWord = WORD_SIZE'(be_merge(MAX_WORD_SIZE'(mem[wr_adr]),
                                          MAX_WORD_SIZE'(wr_data),
                                          MAX_BE'(wr_be)));
  assign postWord   = clr ? '0 : mergedWord;

  // The bulk-clear engine and the user port share a single array write port.
  always_comb begin
    memWe    = 1'b0;
    memWadr  = wr_adr;
    memWdata = postWord;
    if (state == CLEARING) begin
      memWe    = 1'b1;
      memWadr  = clrCnt;
      memWdata = '0;
    end else if (userOp) begin
      memWe = 1'b1;
    end
  end

  // NOTE: the array has no reset.
  // Its contents are defined only by the sequential clear, which lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (memWe) mem[memWadr] <= memWdata;
  end

  // The clear engine sweeps clrCnt from 0 to WORD_COUNT-1, one word per cycle.
  // clr_all restarts the sweep from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEARING;
      clrCnt <= '0;
      busy   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_all) begin
            state  <= CLEARING;
            clrCnt <= '0;
            busy   <= 1'b1;
          end
        end
        CLEARING: begin
          if (clr_all) begin
            clrCnt <= '0;
          end else if (clrCnt == LAST_ADR) begin
            state  <= IDLE;
            clrCnt <= '0;
            busy   <= 1'b0;
          end else begin
            clrCnt <= clrCnt + 1'b1;
          end
        end
        default: begin
          state  <= CLEARING;
          clrCnt <= '0;
          busy   <= 1'b1;
        end
      endcase
    end
  end

  mem_read_port #(
    .WORD_SIZE (WORD_SIZE),
    .WORD_COUNT(WORD_COUNT),
    .RDW_MODE  (RDW_MODE),
    .AW        (AW)
  ) portA (
    .clk    (clk),
    .rst    (rst),
    .busy   (busy),
    .rdEn   (rd_en_a),
    .rdAdr  (rd_adr_a),
    .memWord(mem[rd_adr_a]),
    .wrDone (userOp),
    .wrAdr  (wr_adr),
    .wrWord (postWord),
    .rdData (rd_data_a),
    .rdVld  (rd_vld_a)
  );

  mem_read_port #(
    .WORD_SIZE (WORD_SIZE),
    .WORD_COUNT(WORD_COUNT),
    .RDW_MODE  (RDW_MODE),
    .AW        (AW)
  ) portB (
    .clk    (clk),
    .rst    (rst),
    .busy   (busy),
    .rdEn   (rd_en_b),
    .rdAdr  (rd_adr_b),
    .memWord(mem[rd_adr_b]),
    .wrDone (userOp),
    .wrAdr  (wr_adr),
    .wrWord (postWord),
    .rdData (rd_data_b),
    .rdVld  (rd_vld_b)
  );

endmodule

// File: tb/tb_dual_read_data_mem.sv
// Testbench for dual_read_data_mem.
// Three instances share one stimulus stream:
//   dut 0 : 128 words, old-data read-during-write
//   dut 1 : 128 words, new-data read-during-write
//   dut 2 : 100 words, old-data read-during-write (exercises out-of-range addresses)
// Each read request pushes the hand-computed expected word for every instance/port.
// A negedge monitor pops an expected word whenever rd_vld is high and compares it.
module tb_dual_read_data_mem;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en, clr, clr_all, rd_en_a, rd_en_b;
  logic [6:0]  wr_adr, rd_adr_a, rd_adr_b;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic [31:0] dataA [3];
  logic [31:0] dataB [3];
  logic        vldA  [3];
  logic        vldB  [3];
  logic        busy  [3];

  int compared   = 0;
  int mismatched = 0;

  // Queue index = instance*2 + port (port 0 = A, port 1 = B).
  logic [31:0] expQ [6][$];

  always #5 clk = ~clk;

  dual_read_data_mem #(.WORD_SIZE(32), .WORD_COUNT(128), .RDW_MODE(RDW_OLD)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data), .wr_be(wr_be),
    .clr(clr), .clr_all(clr_all),
    .rd_en_a(rd_en_a), .rd_adr_a(rd_adr_a), .rd_data_a(dataA[0]), .rd_vld_a(vldA[0]),
    .rd_en_b(rd_en_b), .rd_adr_b(rd_adr_b), .rd_data_b(dataB[0]), .rd_vld_b(vldB[0]),
    .busy(busy[0]));

  dual_read_data_mem #(.WORD_SIZE(32), .WORD_COUNT(128), .RDW_MODE(RDW_NEW)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data), .wr_be(wr_be),
    .clr(clr), .clr_all(clr_all),
    .rd_en_a(rd_en_a), .rd_adr_a(rd_adr_a), .rd_data_a(dataA[1]), .rd_vld_a(vldA[1]),
    .rd_en_b(rd_en_b), .rd_adr_b(rd_adr_b), .rd_data_b(dataB[1]), .rd_vld_b(vldB[1]),
    .busy(busy[1]));

  dual_read_data_mem #(.WORD_SIZE(32), .WORD_COUNT(100), .RDW_MODE(RDW_OLD)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data), .wr_be(wr_be),
    .clr(clr), .clr_all(clr_all),
    .rd_en_a(rd_en_a), .rd_adr_a(rd_adr_a), .rd_data_a(dataA[2]), .rd_vld_a(vldA[2]),
    .rd_en_b(rd_en_b), .rd_adr_b(rd_adr_b), .rd_data_b(dataB[2]), .rd_vld_b(vldB[2]),
    .busy(busy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: an output with no expectation queued is itself a failure.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        logic        v;
        logic [31:0] x;
        int          idx;
        v   = (p == 0) ? vldA[d] : vldB[d];
        x   = (p == 0) ? dataA[d] : dataB[d];
        idx = d * 2 + p;
        if (v) begin
          if (expQ[idx].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_vld dut%0d port %s: got data 0x%08h, expected no output",
                     d, (p == 0) ? "A" : "B", x);
          end else begin
            check($sformatf("rd_dut%0d_%s", d, (p == 0) ? "A" : "B"), x, expQ[idx].pop_front());
          end
        end
      end
    end
  end

  // Advance one cycle, then drop all one-cycle strobes.
  task automatic step();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    clr     = 1'b0;
    clr_all = 1'b0;
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
  endtask

  task automatic write(input logic [6:0] adr, input logic [31:0] data, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_adr  = adr;
    wr_data = data;
    wr_be   = be;
  endtask

  task automatic readA(input logic [6:0] adr, input logic [31:0] e0, e1, e2);
    rd_en_a  = 1'b1;
    rd_adr_a = adr;
    expQ[0].push_back(e0);
    expQ[2].push_back(e1);
    expQ[4].push_back(e2);
  endtask

  task automatic readB(input logic [6:0] adr, input logic [31:0] e0, e1, e2);
    rd_en_b  = 1'b1;
    rd_adr_b = adr;
    expQ[1].push_back(e0);
    expQ[3].push_back(e1);
    expQ[5].push_back(e2);
  endtask

  // Fixed 300-cycle window, so a stuck busy cannot hang the run.
  task automatic countBusy(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      c0 += int'(busy[0]);
      c1 += int'(busy[1]);
      c2 += int'(busy[2]);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_busy%0d", tag, d),  32'(busy[d]), 32'd1);
      check($sformatf("%s_vldA%0d", tag, d),  32'(vldA[d]), 32'd0);
      check($sformatf("%s_vldB%0d", tag, d),  32'(vldB[d]), 32'd0);
      check($sformatf("%s_dataA%0d", tag, d), dataA[d],     32'd0);
      check($sformatf("%s_dataB%0d", tag, d), dataB[d],     32'd0);
    end
  endtask

  initial begin
    int c0, c1, c2;
    wr_en = 0; clr = 0; clr_all = 0; rd_en_a = 0; rd_en_b = 0;
    wr_adr = 0; rd_adr_a = 0; rd_adr_b = 0; wr_data = 0; wr_be = 0;

    // Reset state and power-up clear length.
    #2 rst = 1'b1;
    #2 checkResetOutputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    countBusy(c0, c1, c2);
    check("powerup_busy_cycles0", 32'(c0), 32'd128);
    check("powerup_busy_cycles1", 32'(c1), 32'd128);
    check("powerup_busy_cycles2", 32'(c2), 32'd100);
    @(posedge clk); #1;

    // Cleared array reads zero, including the last word.
    readA(7'd0, 0, 0, 0);   readB(7'd64, 0, 0, 0); step();
    readA(7'd127, 0, 0, 0); readB(7'd0, 0, 0, 0);  step();

    // Byte-enable merge; be = 0 is a no-op.
    write(7'd5, 32'hDEADBEEF, 4'hF); step();
    write(7'd5, 32'h11223344, 4'b0101); step();
    readA(7'd5, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44);
    readB(7'd5, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44); step();
    write(7'd5, 32'h00000000, 4'h0); step();
    readA(7'd5, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44); step();

    // Read-during-write: full word, partial bytes, clr.
    write(7'd9, 32'h12345678, 4'hF); step();
    write(7'd9, 32'hAAAA5555, 4'hF);
    readA(7'd9, 32'h12345678, 32'hAAAA5555, 32'h12345678);
    readB(7'd9, 32'h12345678, 32'hAAAA5555, 32'h12345678); step();
    write(7'd9, 32'h0000FFFF, 4'b0011);
    readA(7'd9, 32'hAAAA5555, 32'hAAAAFFFF, 32'hAAAA5555); step();
    readA(7'd9, 32'hAAAAFFFF, 32'hAAAAFFFF, 32'hAAAAFFFF); step();
    clr = 1'b1; wr_adr = 7'd9;
    readB(7'd9, 32'hAAAAFFFF, 32'h00000000, 32'hAAAAFFFF); step();
    readA(7'd9, 0, 0, 0); step();

    // clr beats wr_en.
    write(7'd3, 32'h00000055, 4'hF); step();
    write(7'd3, 32'hFFFFFFFF, 4'hF); clr = 1'b1; step();
    readA(7'd3, 0, 0, 0); step();

    // Out-of-range address only for the 100-word instance.
    write(7'd110, 32'h000000FF, 4'hF); step();
    write(7'd99, 32'hCAFEF00D, 4'hF); step();
    readA(7'd110, 32'h000000FF, 32'h000000FF, 32'h00000000);
    readB(7'd99, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D); step();
    step(); step();

    // Bulk clear restarted at its 40th cycle.
    // A write/read at cycle 150 is dropped where busy; only dut2 has finished by then.
    clr_all = 1'b1; step();
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      c0 += int'(busy[0]);
      c1 += int'(busy[1]);
      c2 += int'(busy[2]);
      if (i == 40) clr_all = 1'b1;
      if (i == 41) clr_all = 1'b0;
      if (i == 150) begin
        wr_en = 1'b1; wr_adr = 7'd5; wr_data = 32'h00000077; wr_be = 4'hF;
        rd_en_a = 1'b1; rd_adr_a = 7'd5;
        expQ[4].push_back(32'h00000000);
      end
      if (i == 151) begin
        wr_en = 1'b0; rd_en_a = 1'b0;
      end
    end
    check("restart_busy_cycles0", 32'(c0), 32'd168);
    check("restart_busy_cycles1", 32'(c1), 32'd168);
    check("restart_busy_cycles2", 32'(c2), 32'd140);
    @(posedge clk); #1;
    readA(7'd5, 32'h00000000, 32'h00000000, 32'h00000077); step();
    write(7'd99, 32'hCAFEF00D, 4'hF); step();
    readB(7'd99, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D); step();

    // Reset in the middle of a clear; rd_data holds while busy until then.
    clr_all = 1'b1; step();
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 30) begin
        for (int d = 0; d < 3; d++) begin
          check($sformatf("hold_dataB%0d", d), dataB[d], 32'hCAFEF00D);
        end
        rd_en_b = 1'b1; rd_adr_b = 7'd0;
      end
      if (i == 31) rd_en_b = 1'b0;
    end
    rst = 1'b1;
    #1 checkResetOutputs("midclear_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    countBusy(c0, c1, c2);
    check("rerun_busy_cycles0", 32'(c0), 32'd128);
    check("rerun_busy_cycles1", 32'(c1), 32'd128);
    check("rerun_busy_cycles2", 32'(c2), 32'd100);
    @(posedge clk); #1;
    readA(7'd99, 0, 0, 0); readB(7'd5, 0, 0, 0); step();
    step(); step();

    for (int q = 0; q < 6; q++) begin
      check($sformatf("drained_q%0d", q), 32'(expQ[q].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
